// File: rtl/fetch_decode_regs.sv
// Y86 F and D pipeline registers with stall/bubble control.
// Optional perf counters: define FETCH_DECODE_PERF_CNT_EN.
`ifndef SAOK
`define SAOK 3'h1
`endif
`ifndef INOP
`define INOP 4'h1
`endif
`ifndef RNONE
`define RNONE 4'hF
`endif

module fetch_decode_regs (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        F_stall_i,
    input  logic        D_stall_i,
    input  logic        D_bubble_i,
    input  logic [63:0] f_predPC_i,
    input  logic [2:0]  f_stat_i,
    input  logic [3:0]  f_icode_i,
    input  logic [3:0]  f_ifun_i,
    input  logic [3:0]  f_rA_i,
    input  logic [3:0]  f_rB_i,
    input  logic [63:0] f_valC_i,
    input  logic [63:0] f_valP_i,
    output logic [63:0] F_predPC_o,
    output logic [2:0]  D_stat_o,
    output logic [3:0]  D_icode_o,
    output logic [3:0]  D_ifun_o,
    output logic [3:0]  D_rA_o,
    output logic [3:0]  D_rB_o,
    output logic [63:0] D_valC_o,
    output logic [63:0] D_valP_o,
    output logic        ctl_err_o,
    output logic [31:0] perf_cyc_o,
    output logic [31:0] perf_fstall_o,
    output logic [31:0] perf_dbub_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            F_predPC_o <= 64'h0;
        end else if (!F_stall_i) begin
            F_predPC_o <= f_predPC_i;
        end
    end

    // Stall wins over bubble; the bubble is a NOP with no register use.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            D_stat_o  <= `SAOK;
            D_icode_o <= `INOP;
            D_ifun_o  <= 4'h0;
            D_rA_o    <= `RNONE;
            D_rB_o    <= `RNONE;
            D_valC_o  <= 64'h0;
            D_valP_o  <= 64'h0;
        end else if (!D_stall_i) begin
            if (D_bubble_i) begin
                D_stat_o  <= `SAOK;
                D_icode_o <= `INOP;
                D_ifun_o  <= 4'h0;
                D_rA_o    <= `RNONE;
                D_rB_o    <= `RNONE;
                D_valC_o  <= 64'h0;
                D_valP_o  <= 64'h0;
            end else begin
                D_stat_o  <= f_stat_i;
                D_icode_o <= f_icode_i;
                D_ifun_o  <= f_ifun_i;
                D_rA_o    <= f_rA_i;
                D_rB_o    <= f_rB_i;
                D_valC_o  <= f_valC_i;
                D_valP_o  <= f_valP_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctl_err_o <= 1'b0;
        end else if (D_stall_i && D_bubble_i) begin
            ctl_err_o <= 1'b1;
        end
    end

`ifdef FETCH_DECODE_PERF_CNT_EN
    logic [31:0] perf_cyc_q;
    logic [31:0] perf_fstall_q;
    logic [31:0] perf_dbub_q;

    // Counters saturate rather than wrap.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf_cyc_q    <= 32'h0;
            perf_fstall_q <= 32'h0;
            perf_dbub_q   <= 32'h0;
        end else begin
            if (perf_cyc_q != 32'hFFFF_FFFF) begin
                perf_cyc_q <= perf_cyc_q + 32'h1;
            end
            if (F_stall_i && perf_fstall_q != 32'hFFFF_FFFF) begin
                perf_fstall_q <= perf_fstall_q + 32'h1;
            end
            if (D_bubble_i && !D_stall_i
                && perf_dbub_q != 32'hFFFF_FFFF) begin
                perf_dbub_q <= perf_dbub_q + 32'h1;
            end
        end
    end

    assign perf_cyc_o    = perf_cyc_q;
    assign perf_fstall_o = perf_fstall_q;
    assign perf_dbub_o   = perf_dbub_q;
`else
    assign perf_cyc_o    = 32'h0;
    assign perf_fstall_o = 32'h0;
    assign perf_dbub_o   = 32'h0;
`endif

endmodule
